// File: rtl/sum_of_n_pkg.sv
// Shared constants for the sum_of_n reduction engine: register map, CTRL bit positions, default width.
package sum_of_n_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [7:0] ADDR_CTRL = 8'd0;
    localparam logic [7:0] ADDR_N    = 8'd1;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_CLR    = 1;

endpackage

// File: rtl/sum_of_n_cfg.sv
// Configuration register file for sum_of_n: N register, IRQ enable, soft-clear and restart pulses.
// SUM_OF_N_IRQ_MASK_EN makes CTRL bit0 a writable IRQ enable; otherwise the enable is tied high.
module sum_of_n_cfg
    import sum_of_n_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wr,
    output logic [7:0] n,
    output logic       irq_en,
    output logic       clr,
    output logic       restart
);

    logic wr_ctrl;
    logic wr_n;

    assign wr_ctrl = wr && (address == ADDR_CTRL);
    assign wr_n    = wr && (address == ADDR_N);

    // Pulses are decoded straight from the strobe so they act on the same edge as the write.
    assign clr     = wr_ctrl && data[CTRL_CLR];
    assign restart = wr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 8'd0;
        end else if (wr_n) begin
            n <= data;
        end
    end

`ifdef SUM_OF_N_IRQ_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b1;
        end else if (wr_ctrl) begin
            irq_en <= data[CTRL_IRQ_EN];
        end
    end
`else
    assign irq_en = 1'b1;
`endif

endmodule

// File: rtl/sum_of_n.sv
// Streaming accumulator: sums N beats into a one-entry result buffer with a level interrupt.
// Result valid the cycle after the last beat; input stalls while a result is pending (SUM_OF_N_IRQ_MASK_EN in cfg).
module sum_of_n
    import sum_of_n_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] in_put,
    input  logic              EN_in_put,
    output logic              RDY_in_put,
    input  logic              EN_out_get,
    output logic [DATA_W-1:0] out_get,
    output logic              RDY_out_get,
    input  logic [7:0]        configure_address,
    input  logic [7:0]        configure_data,
    input  logic              EN_configure,
    output logic              RDY_configure,
    output logic              interrupt,
    output logic              RDY_interrupt
);

    logic [7:0]        n;
    logic              irq_en;
    logic              clr;
    logic              restart;
    logic [DATA_W-1:0] acc;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              accept;
    logic              last;
    logic              pop;

    sum_of_n_cfg u_cfg (
        .clk     (CLK),
        .rst_n   (RST_N),
        .address (configure_address),
        .data    (configure_data),
        .wr      (EN_configure),
        .n       (n),
        .irq_en  (irq_en),
        .clr     (clr),
        .restart (restart)
    );

    assign RDY_configure = 1'b1;
    assign RDY_interrupt = 1'b1;
    assign RDY_in_put    = (n != 8'd0) && !result_valid;
    assign RDY_out_get   = result_valid;
    assign out_get       = result_valid ? result : '0;
    assign interrupt     = result_valid && irq_en;

    // Any configuration write takes priority over a beat in the same cycle.
    assign accept = EN_in_put && RDY_in_put && !EN_configure;
    assign last   = (cnt == n - 8'd1);
    assign pop    = EN_out_get && result_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc          <= '0;
            cnt          <= 8'd0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            if (clr || restart) begin
                acc <= '0;
                cnt <= 8'd0;
            end else if (accept) begin
                if (last) begin
                    result <= acc + in_put;
                    acc    <= '0;
                    cnt    <= 8'd0;
                end else begin
                    acc <= acc + in_put;
                    cnt <= cnt + 8'd1;
                end
            end

            if (clr) begin
                result_valid <= 1'b0;
            end else if (accept && last) begin
                result_valid <= 1'b1;
            end else if (pop) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_of_n.sv
// Directed self-checking bench for sum_of_n.
module tb_sum_of_n;
    import sum_of_n_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_put;
    logic       en_in_put;
    logic       rdy_in_put;
    logic       en_out_get;
    logic [7:0] out_get;
    logic       rdy_out_get;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       en_cfg;
    logic       rdy_cfg;
    logic       interrupt;
    logic       rdy_interrupt;

    int checks;
    int errors;

    sum_of_n #(.DATA_W(8)) dut (
        .CLK               (clk),
        .RST_N             (rst_n),
        .in_put            (in_put),
        .EN_in_put         (en_in_put),
        .RDY_in_put        (rdy_in_put),
        .EN_out_get        (en_out_get),
        .out_get           (out_get),
        .RDY_out_get       (rdy_out_get),
        .configure_address (cfg_addr),
        .configure_data    (cfg_data),
        .EN_configure      (en_cfg),
        .RDY_configure     (rdy_cfg),
        .interrupt         (interrupt),
        .RDY_interrupt     (rdy_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        cfg_addr = a;
        cfg_data = d;
        en_cfg   = 1'b1;
        tick();
        en_cfg   = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d);
        in_put    = d;
        en_in_put = 1'b1;
        tick();
        en_in_put = 1'b0;
    endtask

    task automatic pop();
        en_out_get = 1'b1;
        tick();
        en_out_get = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (rdy_in_put !== 1'b0) begin errors++; $display("FAIL reset_rdy_in got %b exp 0", rdy_in_put); end
        checks++; if (rdy_out_get !== 1'b0) begin errors++; $display("FAIL reset_rdy_out got %b exp 0", rdy_out_get); end
        checks++; if (out_get !== 8'h00) begin errors++; $display("FAIL reset_out_get got %h exp 00", out_get); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", interrupt); end
        checks++; if (rdy_cfg !== 1'b1 || rdy_interrupt !== 1'b1) begin errors++; $display("FAIL reset_const_rdy got %b%b exp 11", rdy_cfg, rdy_interrupt); end
        // N == 0: beats offered must not be taken
        in_put    = 8'h33;
        en_in_put = 1'b1;
        repeat (3) tick();
        en_in_put = 1'b0;
        checks++; if (rdy_out_get !== 1'b0 || rdy_in_put !== 1'b0) begin errors++; $display("FAIL idle_n0 got rdy_out=%b rdy_in=%b exp 0 0", rdy_out_get, rdy_in_put); end
    endtask

    task automatic test_drop_on_cfg();
        in_put    = 'x;
        en_in_put = 1'b1;
        cfg_write(ADDR_N, 8'd1);
        checks++; if (rdy_in_put !== 1'b1) begin errors++; $display("FAIL n1_rdy_in got %b exp 1", rdy_in_put); end
        cfg_write(ADDR_N, 8'd2);
        en_in_put = 1'b0;
        checks++; if (rdy_out_get !== 1'b0) begin errors++; $display("FAIL x_beat_dropped got rdy_out=%b exp 0", rdy_out_get); end
        beat(8'h0F);
        checks++; if (rdy_out_get !== 1'b0) begin errors++; $display("FAIL first_of_two got rdy_out=%b exp 0", rdy_out_get); end
        beat(8'h0F);
        checks++; if (out_get !== 8'h1E) begin errors++; $display("FAIL sum_1e got %h exp 1e", out_get); end
        checks++; if (rdy_out_get !== 1'b1 || interrupt !== 1'b1) begin errors++; $display("FAIL sum_1e_flags got rdy_out=%b irq=%b exp 1 1", rdy_out_get, interrupt); end
        checks++; if (rdy_in_put !== 1'b0) begin errors++; $display("FAIL stall_pending got %b exp 0", rdy_in_put); end
        // Offered beat while result pending is ignored
        beat(8'h55);
        checks++; if (out_get !== 8'h1E || rdy_in_put !== 1'b0) begin errors++; $display("FAIL hold_pending got %h rdy_in=%b exp 1e 0", out_get, rdy_in_put); end
        pop();
        checks++; if (rdy_out_get !== 1'b0 || out_get !== 8'h00 || interrupt !== 1'b0) begin errors++; $display("FAIL after_pop got rdy=%b out=%h irq=%b exp 0 00 0", rdy_out_get, out_get, interrupt); end
    endtask

    task automatic test_wrap();
        cfg_write(ADDR_N, 8'd3);
        beat(8'h80);
        beat(8'h90);
        beat(8'h10);
        checks++; if (out_get !== 8'h20 || rdy_out_get !== 1'b1) begin errors++; $display("FAIL wrap got %h rdy=%b exp 20 1", out_get, rdy_out_get); end
    endtask

    task automatic test_back_to_back();
        // N write with a pending result keeps the result
        cfg_write(ADDR_N, 8'd2);
        checks++; if (out_get !== 8'h20 || rdy_out_get !== 1'b1) begin errors++; $display("FAIL keep_on_n_write got %h rdy=%b exp 20 1", out_get, rdy_out_get); end
        pop();
        checks++; if (rdy_in_put !== 1'b1 || interrupt !== 1'b0) begin errors++; $display("FAIL rdy_after_pop got rdy_in=%b irq=%b exp 1 0", rdy_in_put, interrupt); end
        beat(8'h01);
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_mid_frame got %b exp 0", interrupt); end
        beat(8'h02);
        checks++; if (out_get !== 8'h03 || interrupt !== 1'b1) begin errors++; $display("FAIL next_frame got %h irq=%b exp 03 1", out_get, interrupt); end
        pop();
    endtask

    task automatic test_restart();
        cfg_write(ADDR_N, 8'd3);
        beat(8'h05);
        cfg_write(ADDR_N, 8'd2);
        beat(8'h01);
        checks++; if (rdy_out_get !== 1'b0) begin errors++; $display("FAIL restart_early got rdy=%b exp 0", rdy_out_get); end
        beat(8'h01);
        checks++; if (out_get !== 8'h02 || rdy_out_get !== 1'b1) begin errors++; $display("FAIL restart_n got %h exp 02", out_get); end
        pop();

        beat(8'h05);
        cfg_write(ADDR_CTRL, 8'h03);
        beat(8'h01);
        beat(8'h01);
        checks++; if (out_get !== 8'h02) begin errors++; $display("FAIL restart_clr got %h exp 02", out_get); end
        // Soft clear also drops a pending result
        cfg_write(ADDR_CTRL, 8'h03);
        checks++; if (rdy_out_get !== 1'b0 || out_get !== 8'h00) begin errors++; $display("FAIL clr_result got rdy=%b out=%h exp 0 00", rdy_out_get, out_get); end

        // Beat coinciding with a write to an unmapped address is dropped
        in_put    = 8'h01;
        en_in_put = 1'b1;
        cfg_write(8'h07, 8'hFF);
        en_in_put = 1'b0;
        beat(8'h01);
        checks++; if (rdy_out_get !== 1'b0) begin errors++; $display("FAIL cfg_wins got rdy=%b exp 0", rdy_out_get); end
        beat(8'h01);
        checks++; if (out_get !== 8'h02) begin errors++; $display("FAIL cfg_wins_sum got %h exp 02", out_get); end
        pop();
    endtask

    task automatic test_irq_mask();
        cfg_write(ADDR_CTRL, 8'h00);
        beat(8'h10);
        beat(8'h20);
`ifdef SUM_OF_N_IRQ_MASK_EN
        checks++; if (rdy_out_get !== 1'b1 || interrupt !== 1'b0) begin errors++; $display("FAIL irq_masked got rdy=%b irq=%b exp 1 0", rdy_out_get, interrupt); end
        cfg_write(ADDR_CTRL, 8'h01);
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b exp 1", interrupt); end
`else
        checks++; if (rdy_out_get !== 1'b1 || interrupt !== 1'b1) begin errors++; $display("FAIL irq_nomask got rdy=%b irq=%b exp 1 1", rdy_out_get, interrupt); end
`endif
        checks++; if (out_get !== 8'h30) begin errors++; $display("FAIL irq_sum got %h exp 30", out_get); end
    endtask

    task automatic test_async_reset();
        // Result 0x30 is pending; reset mid-cycle must clear without an edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rdy_out_get !== 1'b0 || out_get !== 8'h00 || interrupt !== 1'b0 || rdy_in_put !== 1'b0) begin errors++; $display("FAIL async_reset got rdy_out=%b out=%h irq=%b rdy_in=%b exp 0 00 0 0", rdy_out_get, out_get, interrupt, rdy_in_put); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in_put     = 8'h00;
        en_in_put  = 1'b0;
        en_out_get = 1'b0;
        cfg_addr   = 8'h00;
        cfg_data   = 8'h00;
        en_cfg     = 1'b0;

        test_reset();
        test_drop_on_cfg();
        test_wrap();
        test_back_to_back();
        test_restart();
        test_irq_mask();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
